corec_pwr_sw: RTL and testbench

Power-switch sequencer for the gated core domain (corec), on `pmu_clk`. It sits directly downstream of the PMU power-gating FSM:
- It consumes `pmu_corec_sleep_in` and `pmu_corec_isolation`.
- It drives the segmented power-switch chain one segment at a time, to limit in-rush current.
- It returns `corec_pmu_sleep_out` once the chain acknowledges power-off.
- It also reports domain power-good and a sticky switch-timeout error.

---
 rtl/corec_pwr_sw.sv | 147 ++++++++++++++
 tb/tb_corec_pwr_sw.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/corec_pwr_sw.sv
// Power-switch sequencer for the gated core domain: walks the segmented switch
// chain one segment per STEP_DLY cycles and handshakes power state with the PMU.
module corec_pwr_sw #(
  parameter int SEG_NUM    = 4,
  parameter int STEP_DLY   = 8,
  parameter int SETTLE_DLY = 16,
  parameter int TMO        = 256
) (
  input  logic               pmu_clk,
  input  logic               pad_cpu_rst_b,
  input  logic               pmu_corec_sleep_in,
  input  logic               pmu_corec_isolation,
  input  logic [SEG_NUM-1:0] pwr_sw_ack_in,
  output logic               corec_pmu_sleep_out,
  output logic [SEG_NUM-1:0] pwr_sw_en,
  output logic               corec_pwr_good,
  output logic               pwr_sw_err
);

  localparam int IW = $clog2(SEG_NUM);
  localparam int CW = $clog2(STEP_DLY);
  localparam int SW = $clog2(SETTLE_DLY + 1);
  localparam int TW = $clog2(TMO + 1);

  localparam logic [IW-1:0] IDX_TOP     = IW'(SEG_NUM - 1);
  localparam logic [CW-1:0] STEP_LAST   = CW'(STEP_DLY - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_DLY - 1);
  localparam logic [TW-1:0] TMO_LAST    = TW'(TMO - 1);

  typedef enum logic [2:0] {
    S_ON, S_OFF_SEQ, S_OFF_WAIT, S_OFF, S_ON_SEQ, S_SETTLE
  } state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      step, step_nxt;
  logic [IW-1:0]      idx, idx_nxt;
  logic [SW-1:0]      settle, settle_nxt;
  logic [TW-1:0]      tmo, tmo_nxt;
  logic [SEG_NUM-1:0] en_nxt;
  logic               err_nxt;
  logic [SEG_NUM-1:0] ack_p0, ack_sync;

  always_ff @(posedge pmu_clk or negedge pad_cpu_rst_b) begin
    if (!pad_cpu_rst_b) begin
      state          <= S_ON;
      step           <= '0;
      idx            <= '0;
      settle         <= '0;
      tmo            <= '0;
      pwr_sw_en      <= '1;
      pwr_sw_err     <= 1'b0;
      corec_pwr_good <= 1'b1;
      ack_p0         <= '0;
      ack_sync       <= '0;
    end else begin
      state          <= state_nxt;
      step           <= step_nxt;
      idx            <= idx_nxt;
      settle         <= settle_nxt;
      tmo            <= tmo_nxt;
      pwr_sw_en      <= en_nxt;
      pwr_sw_err     <= err_nxt;
      corec_pwr_good <= (state_nxt == S_ON);
      ack_p0         <= pwr_sw_ack_in;
      ack_sync       <= ack_p0;
    end
  end

  always_comb begin
    state_nxt  = state;
    step_nxt   = step;
    idx_nxt    = idx;
    settle_nxt = settle;
    tmo_nxt    = (tmo == TMO_LAST) ? tmo : tmo + TW'(1);
    en_nxt     = pwr_sw_en;
    err_nxt    = pwr_sw_err;
    case (state)
      S_ON: begin
        if (pmu_corec_sleep_in && pmu_corec_isolation) begin
          state_nxt = S_OFF_SEQ;
          step_nxt  = '0;
          idx_nxt   = IDX_TOP;
        end else if (pmu_corec_sleep_in) begin
          err_nxt = 1'b1;
        end
      end
      S_OFF_SEQ: begin
        if (step == STEP_LAST) begin
          en_nxt[idx] = 1'b0;
          step_nxt    = '0;
          if (idx == '0) begin
            state_nxt = S_OFF_WAIT;
            tmo_nxt   = '0;
          end else begin
            idx_nxt = idx - IW'(1);
          end
        end else begin
          step_nxt = step + CW'(1);
        end
      end
      S_OFF_WAIT: begin
        // A missing ack is flagged but never blocks the handshake to the PMU.
        if (ack_sync == '0) begin
          state_nxt = S_OFF;
        end else if (tmo == TMO_LAST) begin
          state_nxt = S_OFF;
          err_nxt   = 1'b1;
        end
      end
      S_OFF: begin
        if (!pmu_corec_sleep_in) begin
          state_nxt = S_ON_SEQ;
          step_nxt  = '0;
          idx_nxt   = '0;
        end
      end
      S_ON_SEQ: begin
        if (step == STEP_LAST) begin
          en_nxt[idx] = 1'b1;
          step_nxt    = '0;
          if (idx == IDX_TOP) begin
            state_nxt  = S_SETTLE;
            settle_nxt = '0;
            tmo_nxt    = '0;
          end else begin
            idx_nxt = idx + IW'(1);
          end
        end else begin
          step_nxt = step + CW'(1);
        end
      end
      S_SETTLE: begin
        settle_nxt = (settle == SETTLE_LAST) ? settle : settle + SW'(1);
        if ((ack_sync == '1) && (settle >= SETTLE_LAST)) begin
          state_nxt = S_ON;
        end else if (tmo == TMO_LAST) begin
          state_nxt = S_ON;
          err_nxt   = 1'b1;
        end
      end
      default: state_nxt = S_ON;
    endcase
  end

  assign corec_pmu_sleep_out = (state == S_OFF);

endmodule

// File: tb/tb_corec_pwr_sw.sv
// Scoreboard bench for corec_pwr_sw: expected output snapshots are queued with
// their cycle stamp when stimulus is driven, and compared when that cycle arrives.
module tb_corec_pwr_sw;

  logic       pmu_clk = 1'b0;
  logic       pad_cpu_rst_b;
  logic       pmu_corec_sleep_in;
  logic       pmu_corec_isolation;
  logic [3:0] pwr_sw_ack_in;
  logic       corec_pmu_sleep_out;
  logic [3:0] pwr_sw_en;
  logic       corec_pwr_good;
  logic       pwr_sw_err;
  logic       ack_hold;

  int cyc = 0;
  int total = 0;
  int passed = 0;
  int fails = 0;

  typedef struct {
    int         at;
    logic [6:0] v;
    string      tag;
  } exp_t;
  exp_t sb[$];

  corec_pwr_sw dut (
    .pmu_clk             (pmu_clk),
    .pad_cpu_rst_b       (pad_cpu_rst_b),
    .pmu_corec_sleep_in  (pmu_corec_sleep_in),
    .pmu_corec_isolation (pmu_corec_isolation),
    .pwr_sw_ack_in       (pwr_sw_ack_in),
    .corec_pmu_sleep_out (corec_pmu_sleep_out),
    .pwr_sw_en           (pwr_sw_en),
    .corec_pwr_good      (corec_pwr_good),
    .pwr_sw_err          (pwr_sw_err)
  );

  always #5 pmu_clk = ~pmu_clk;
  always @(posedge pmu_clk) cyc <= cyc + 1;

  // Switch chain model: acks follow the enables unless forced stuck-on.
  assign pwr_sw_ack_in = ack_hold ? 4'hf : pwr_sw_en;

  function automatic logic [6:0] pk(bit err, bit good, bit so, logic [3:0] en);
    return {err, good, so, en};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
    end else begin
      passed++;
    end
  endtask

  task automatic push(input int at, input logic [3:0] en, input bit so, input bit good,
                      input bit err, input string tag);
    exp_t e;
    e.at  = at;
    e.v   = pk(err, good, so, en);
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic go_until(input int n);
    while (cyc < n) @(negedge pmu_clk);
  endtask

  always @(negedge pmu_clk) begin
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      check(e.tag, {25'd0, pwr_sw_err, corec_pwr_good, corec_pmu_sleep_out, pwr_sw_en},
            {25'd0, e.v});
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0, u, c;
    pad_cpu_rst_b       = 1'b0;
    pmu_corec_sleep_in  = 1'b0;
    pmu_corec_isolation = 1'b0;
    ack_hold            = 1'b0;
    repeat (3) @(negedge pmu_clk);
    check("reset_vals", {25'd0, pwr_sw_err, corec_pwr_good, corec_pmu_sleep_out, pwr_sw_en},
          {25'd0, pk(0, 1, 0, 4'hf)});
    pad_cpu_rst_b = 1'b1;

    // Idle after reset
    c = cyc;
    push(c + 10, 4'hf, 0, 1, 0, "idle10");
    push(c + 50, 4'hf, 0, 1, 0, "idle50");
    push(c + 100, 4'hf, 0, 1, 0, "idle100");
    go_until(c + 101);

    // Full power-off
    pmu_corec_sleep_in  = 1'b1;
    pmu_corec_isolation = 1'b1;
    t0 = cyc + 1;
    push(t0,      4'hf, 0, 0, 0, "off_entry");
    push(t0 + 7,  4'hf, 0, 0, 0, "off_pre8");
    push(t0 + 8,  4'h7, 0, 0, 0, "off_8");
    push(t0 + 15, 4'h7, 0, 0, 0, "off_pre16");
    push(t0 + 16, 4'h3, 0, 0, 0, "off_16");
    push(t0 + 24, 4'h1, 0, 0, 0, "off_24");
    push(t0 + 32, 4'h0, 0, 0, 0, "off_32");
    push(t0 + 34, 4'h0, 0, 0, 0, "off_34");
    push(t0 + 35, 4'h0, 1, 0, 0, "sleep_out_35");
    push(t0 + 39, 4'h0, 1, 0, 0, "off_hold");
    go_until(t0 + 40);

    // Power-on
    pmu_corec_sleep_in = 1'b0;
    u = cyc + 1;
    push(u,      4'h0, 0, 0, 0, "on_entry");
    push(u + 7,  4'h0, 0, 0, 0, "on_pre8");
    push(u + 8,  4'h1, 0, 0, 0, "on_8");
    push(u + 16, 4'h3, 0, 0, 0, "on_16");
    push(u + 24, 4'h7, 0, 0, 0, "on_24");
    push(u + 32, 4'hf, 0, 0, 0, "on_32");
    push(u + 47, 4'hf, 0, 0, 0, "settle_47");
    push(u + 48, 4'hf, 0, 1, 0, "good_48");
    go_until(u + 52);

    // Request dropped mid power-off: completes, one-cycle OFF, then power-on
    pmu_corec_sleep_in = 1'b1;
    t0 = cyc + 1;
    u  = t0 + 36;
    push(t0 + 8,  4'h7, 0, 0, 0, "drop_8");
    push(t0 + 32, 4'h0, 0, 0, 0, "drop_32");
    push(t0 + 34, 4'h0, 0, 0, 0, "drop_34");
    push(t0 + 35, 4'h0, 1, 0, 0, "drop_pulse");
    push(u,       4'h0, 0, 0, 0, "drop_pulse_end");
    push(u + 8,   4'h1, 0, 0, 0, "drop_on_8");
    push(u + 32,  4'hf, 0, 0, 0, "drop_on_32");
    push(u + 48,  4'hf, 0, 1, 0, "drop_good");
    go_until(t0 + 10);
    pmu_corec_sleep_in = 1'b0;
    go_until(u + 50);

    // Reset in the middle of power-off
    pmu_corec_sleep_in = 1'b1;
    t0 = cyc + 1;
    push(t0 + 16, 4'h3, 0, 0, 0, "mrst_16");
    push(t0 + 19, 4'h3, 0, 0, 0, "mrst_19");
    go_until(t0 + 20);
    #2 pad_cpu_rst_b = 1'b0;
    #1;
    check("async_rst_en", {28'd0, pwr_sw_en}, 32'hf);
    check("async_rst_good", {31'd0, corec_pwr_good}, 32'd1);
    pmu_corec_sleep_in = 1'b0;
    @(negedge pmu_clk);
    pad_cpu_rst_b = 1'b1;

    // Request without isolation
    pmu_corec_isolation = 1'b0;
    pmu_corec_sleep_in  = 1'b1;
    c = cyc;
    push(c + 1,  4'hf, 0, 1, 1, "noiso_err");
    push(c + 20, 4'hf, 0, 1, 1, "noiso_stay");
    go_until(c + 21);
    pmu_corec_sleep_in = 1'b0;
    c = cyc;
    push(c + 5, 4'hf, 0, 1, 1, "noiso_sticky");
    go_until(c + 6);

    pad_cpu_rst_b = 1'b0;
    @(negedge pmu_clk);
    pad_cpu_rst_b = 1'b1;
    check("rst_clears_err", {31'd0, pwr_sw_err}, 32'd0);

    // Ack stuck on during power-off: timeout, then sticky error through power-on
    ack_hold            = 1'b1;
    pmu_corec_isolation = 1'b1;
    pmu_corec_sleep_in  = 1'b1;
    t0 = cyc + 1;
    push(t0 + 32,  4'h0, 0, 0, 0, "tmo_wait");
    push(t0 + 287, 4'h0, 0, 0, 0, "tmo_pre");
    push(t0 + 288, 4'h0, 1, 0, 1, "tmo_expire");
    go_until(t0 + 289);
    ack_hold           = 1'b0;
    pmu_corec_sleep_in = 1'b0;
    u = cyc + 1;
    push(u,      4'h0, 0, 0, 1, "tmo_on_entry");
    push(u + 32, 4'hf, 0, 0, 1, "tmo_on_32");
    push(u + 47, 4'hf, 0, 0, 1, "tmo_settle");
    push(u + 48, 4'hf, 0, 1, 1, "tmo_err_sticky");
    go_until(u + 52);

    check("sb_drain", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
